// File: rtl/lfsr_bank.sv
// rtl/lfsr_bank.sv - multi-channel Fibonacci LFSR bank with valid/ready output stage
module lfsr_bank #(
  parameter int              WIDTH    = 10,
  parameter logic [WIDTH-1:0] TAPS    = 'h240,
  parameter int              CHANNELS = 4,
  parameter int              STEP     = 1,
  parameter int              CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [WIDTH-1:0]          seed,
  input  logic                      reseed_en,
  input  logic                      enable,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [CHANNELS*WIDTH-1:0] rand_val,
  output logic [CNT_W-1:0]          seq_cnt,
  output logic                      seed_fix
);

  function automatic logic [WIDTH-1:0] advance_n(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] t;
    t = s;
    for (int i = 0; i < STEP; i++) begin
      t = {t[WIDTH-2:0], ^(t & TAPS)};
    end
    return t;
  endfunction

  function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] v, input int r);
    logic [WIDTH-1:0] o;
    o = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o[(i + r) % WIDTH] = v[i];
    end
    return o;
  endfunction

  logic [WIDTH-1:0]          state_q [CHANNELS];
  logic [WIDTH-1:0]          adv_d   [CHANNELS];
  logic [WIDTH-1:0]          seed_d  [CHANNELS];
  logic [CHANNELS-1:0]       zero_d;
  logic [CHANNELS*WIDTH-1:0] adv_flat;
  logic                      do_advance;
  logic                      do_drain;

  // A full output register may only be overwritten in the same cycle it is consumed.
  assign do_advance = enable && (!out_valid || out_ready);
  assign do_drain   = !enable && out_valid && out_ready;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    localparam logic [WIDTH-1:0] CIDX = WIDTH'(c);
    logic [WIDTH-1:0] derived;

    assign derived   = rotl(seed, c % WIDTH) ^ CIDX;
    assign zero_d[c] = (derived == '0);
    // An all-zero LFSR state would lock up; substitute a channel-unique non-zero value.
    assign seed_d[c] = zero_d[c] ? ~CIDX : derived;
    assign adv_d[c]  = advance_n(state_q[c]);
    assign adv_flat[c*WIDTH +: WIDTH] = adv_d[c];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= WIDTH'(c + 1);
      end
      out_valid <= 1'b0;
      rand_val  <= '0;
      seq_cnt   <= '0;
      seed_fix  <= 1'b0;
    end else begin
      seed_fix <= 1'b0;
      if (reseed_en) begin
        for (int c = 0; c < CHANNELS; c++) begin
          state_q[c] <= seed_d[c];
        end
        out_valid <= 1'b0;
        seq_cnt   <= '0;
        seed_fix  <= |zero_d;
      end else if (do_advance) begin
        for (int c = 0; c < CHANNELS; c++) begin
          state_q[c] <= adv_d[c];
        end
        rand_val  <= adv_flat;
        out_valid <= 1'b1;
        seq_cnt   <= seq_cnt + CNT_W'(1);
      end else if (do_drain) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lfsr_bank.sv
// tb/tb_lfsr_bank.sv - randomized and directed checks of lfsr_bank against a behavioural model
module tb_lfsr_bank;
  localparam int W  = 10;
  localparam int CH = 4;
  localparam int CW = 16;

  logic            clk = 1'b0;
  logic            reset_n;
  logic [W-1:0]    seed;
  logic            reseed_en;
  logic            enable;
  logic            out_ready;
  logic            out_valid;
  logic [CH*W-1:0] rand_val;
  logic [CW-1:0]   seq_cnt;
  logic            seed_fix;

  logic            out_valid4;
  logic [2*W-1:0]  rand_val4;
  logic [CW-1:0]   seq_cnt4;
  logic            seed_fix4;

  int n_pass  = 0;
  int n_total = 0;

  int m_state [CH];
  int m_out   [CH];
  bit m_valid;
  int m_cnt;
  bit m_fix;

  lfsr_bank #(.WIDTH(W), .TAPS(10'h240), .CHANNELS(CH), .STEP(1), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n), .seed(seed), .reseed_en(reseed_en), .enable(enable),
    .out_ready(out_ready), .out_valid(out_valid), .rand_val(rand_val), .seq_cnt(seq_cnt),
    .seed_fix(seed_fix)
  );

  lfsr_bank #(.WIDTH(W), .TAPS(10'h240), .CHANNELS(2), .STEP(4), .CNT_W(CW)) dut4 (
    .clk(clk), .reset_n(reset_n), .seed(seed), .reseed_en(reseed_en), .enable(enable),
    .out_ready(out_ready), .out_valid(out_valid4), .rand_val(rand_val4), .seq_cnt(seq_cnt4),
    .seed_fix(seed_fix4)
  );

  always #5 clk = ~clk;

  function automatic int lfsr_adv(int s, int steps);
    int v;
    v = s;
    for (int i = 0; i < steps; i++) begin
      v = ((v * 2) + ($countones(v & 'h240) % 2)) % 1024;
    end
    return v;
  endfunction

  function automatic int rot_left(int v, int r);
    return ((v << r) | (v >> (W - r))) & 'h3FF;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_state[c] = c + 1;
      m_out[c]   = 0;
    end
    m_valid = 0;
    m_cnt   = 0;
    m_fix   = 0;
  endtask

  task automatic model_step(input bit re, input bit en, input bit rdy, input int sd);
    int d;
    m_fix = 0;
    if (re) begin
      for (int c = 0; c < CH; c++) begin
        d = rot_left(sd, c % W) ^ c;
        if (d == 0) begin
          d     = 'h3FF ^ c;
          m_fix = 1;
        end
        m_state[c] = d;
      end
      m_valid = 0;
      m_cnt   = 0;
    end else if (en && (!m_valid || rdy)) begin
      for (int c = 0; c < CH; c++) begin
        m_state[c] = lfsr_adv(m_state[c], 1);
        m_out[c]   = m_state[c];
      end
      m_valid = 1;
      m_cnt   = (m_cnt + 1) % 65536;
    end else if (!en && m_valid && rdy) begin
      m_valid = 0;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
    check({tag, ".cnt"}, 64'(seq_cnt), 64'(m_cnt));
    check({tag, ".fix"}, 64'(seed_fix), 64'(m_fix));
    for (int c = 0; c < CH; c++) begin
      check($sformatf("%s.ch%0d", tag, c), 64'(rand_val[c*W +: W]), 64'(m_out[c]));
    end
  endtask

  task automatic cycle(input string tag, input bit re, input bit en, input bit rdy, input int sd);
    reseed_en = re;
    enable    = en;
    out_ready = rdy;
    seed      = W'(sd);
    model_step(re, en, rdy, sd);
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    reset_n   = 1'b0;
    reseed_en = 1'b0;
    enable    = 1'b0;
    out_ready = 1'b0;
    seed      = '0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
  endtask

  initial begin
    int seeds [6];
    int first_ret;
    int repeats;
    int v;
    bit seen [1024];

    seeds[0] = 'h000; seeds[1] = 'h3FF; seeds[2] = 'h200;
    seeds[3] = 'h180; seeds[4] = 'h001; seeds[5] = 'h155;

    do_reset();
    check_all("reset");

    cycle("first", 0, 1, 1, 0);
    check("first.ch0_const", 64'(rand_val[9:0]), 64'h002);
    check("first.ch1_const", 64'(rand_val[19:10]), 64'h004);
    check("first.cnt_const", 64'(seq_cnt), 64'd1);
    check("step4.ch0", 64'(rand_val4[9:0]), 64'h010);
    check("step4.ch1", 64'(rand_val4[19:10]), 64'(lfsr_adv(2, 4)));

    cycle("reseed3ff", 1, 0, 0, 'h3FF);
    cycle("adv3ff", 0, 1, 0, 0);
    check("adv3ff.ch0_const", 64'(rand_val[9:0]), 64'h3FE);
    check("adv3ff.ch1_const", 64'(rand_val[19:10]), 64'h3FC);

    cycle("reseed0", 1, 0, 1, 'h000);
    check("reseed0.fix_const", 64'(seed_fix), 64'd1);
    cycle("fixclr", 0, 0, 0, 0);
    cycle("adv0", 0, 1, 1, 0);
    check("adv0.ch0_const", 64'(rand_val[9:0]), 64'(lfsr_adv('h3FF, 1)));
    check("adv0.ch1_const", 64'(rand_val[19:10]), 64'h002);

    cycle("word", 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) cycle("stall", 0, 1, 0, 0);
    cycle("resume", 0, 1, 1, 0);

    cycle("re_en", 1, 1, 1, 'h2A5);
    check("re_en.valid_const", 64'(out_valid), 64'd0);
    check("re_en.cnt_const", 64'(seq_cnt), 64'd0);

    cycle("fill", 0, 1, 1, 0);
    cycle("drain", 0, 0, 1, 0);
    cycle("idle_rdy", 0, 0, 1, 0);

    for (int k = 0; k < 400; k++) begin
      int sd;
      sd = ($urandom_range(0, 3) == 0) ? seeds[$urandom_range(0, 5)] : int'($urandom_range(0, 1023));
      cycle("rand", ($urandom_range(0, 15) == 0), bit'($urandom_range(0, 1)),
            ($urandom_range(0, 3) != 0), sd);
    end

    cycle("pre_arst", 0, 1, 1, 0);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    check_all("arst");
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    for (int i = 0; i < 1024; i++) seen[i] = 0;
    first_ret = -1;
    repeats   = 0;
    for (int k = 1; k <= 1023; k++) begin
      cycle("period", 0, 1, 1, 0);
      v = int'(rand_val[9:0]);
      if (seen[v]) repeats++;
      seen[v] = 1;
      if (v == 1 && first_ret < 0) first_ret = k;
    end
    check("period.first_return", 64'(first_ret), 64'd1023);
    check("period.repeats", 64'(repeats), 64'd0);
    check("period.cnt", 64'(seq_cnt), 64'd1023);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/lfsr_bank.md
# lfsr_bank

Multi-channel, parametrised Fibonacci LFSR random source. It replaces the single 10-bit generator on the FPGA datapath and supplies CHANNELS independent pseudo-random words per accepted transfer. It adds a valid/ready output stage, multi-step advance per cycle, per-channel seed derivation and zero-seed protection. It sits between the host-facing seed/control registers and the sampling consumers.

## Interface
- WIDTH, 10: LFSR state width in bits (≥ 3).
- TAPS, 10'h240: feedback tap mask. Bit i set means state[i] enters the XOR. The default is x^10 + x^7 + 1.
- CHANNELS, 4: number of independent LFSR channels (≥ 1, < 2^WIDTH).
- STEP, 1: shifts applied per advance (1..WIDTH).
- CNT_W, 16: width of the sequence counter.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- seed  in  WIDTH  base seed, sampled when reseed_en=1.
- reseed_en  in  1  load per-channel seeds derived from `seed`.
- enable  in  1  request one advance/output word.
- out_ready  in  1  consumer accepts rand_val.
- out_valid  out  1  rand_val holds an unconsumed word.
- rand_val  out  CHANNELS*WIDTH  channel c is in bits [c*WIDTH +: WIDTH].
- seq_cnt  out  CNT_W  advances since the last reset or reseed.
- seed_fix  out  1  one-cycle pulse: at least one derived seed was zero and was substituted.

## Operation
- Each channel holds a state register s_c.
  - Single shift: fb = XOR-reduce(s_c & TAPS); s_c ← {s_c[WIDTH-2:0], fb}.
  - One advance applies STEP single shifts, unrolled combinationally in one cycle.
- Reset (asynchronous, reset_n=0):
  - s_c = c+1.
  - out_valid=0, rand_val=0, seq_cnt=0, seed_fix=0.
- Seed derivation on reseed: d_c = rotl(seed, c mod WIDTH) XOR c, with c zero-extended to WIDTH.
  - If d_c == 0, load s_c = all-ones XOR c instead and pulse seed_fix.
- Priority per cycle: reseed > advance > drain > hold.
- Reseed (reseed_en=1):
  - Load all s_c.
  - out_valid←0, rand_val unchanged, seq_cnt←0.
  - enable is ignored that cycle.
- Advance when enable=1 AND (out_valid=0 OR out_ready=1):
  - All s_c advance by STEP.
  - rand_val ← the new states.
  - out_valid←1.
  - seq_cnt←seq_cnt+1, wrapping from 2^CNT_W−1 to 0.
- Drain when enable=0 AND out_valid=1 AND out_ready=1: out_valid←0; rand_val holds its last value.
- Stall when out_valid=1 AND out_ready=0:
  - s_c, rand_val, out_valid and seq_cnt all hold, regardless of enable.
- out_ready is ignored while out_valid=0.

## Timing
- Advance latency: 1 cycle. enable accepted at edge n gives out_valid=1 with the new word after edge n.
- Throughput: one word per cycle while enable=1 and out_ready=1.
- Reseed: the new states are visible through the next advance. The earliest output is 2 cycles after reseed_en.
- seed_fix is asserted exactly the cycle after the reseed edge, then cleared.
- Reset assertion mid-transfer drops out_valid immediately, asynchronously. Deassertion is synchronised externally.
- A transfer completes on any edge where out_valid=1 AND out_ready=1.

## Test plan
- Reset, then enable=1, out_ready=1, defaults with CHANNELS=2 -> first word ch0=0x002, ch1=0x004; seq_cnt=1.
- reseed_en with seed=0x3FF, then one advance -> preload ch0=0x3FF, ch1=0x3FE; output ch0=0x3FE, ch1=0x3FC.
- reseed_en with seed=0x000 -> seed_fix pulses one cycle; s_0=0x3FF, s_1=0x001.
- Hold out_ready=0 with enable=1 for 3 cycles after a word -> rand_val, seq_cnt and state are unchanged; raising out_ready resumes the sequence without skipping.
- STEP=4, advance from reset -> ch0=0x010. With STEP=1, 1023 advances from 0x001 -> ch0 returns to 0x001, with no repeat earlier; seq_cnt=1023.
- reseed_en and enable in the same cycle -> no advance, out_valid=0, seq_cnt=0. Separately, assert reset_n low mid-stream -> all outputs at their reset values without a clock edge.
